// File: rtl/sync_frame_tx_1101.sv
// Serial frame transmitter: sync word 1101, then the payload MSB-first, then GAP idle zeros.
// Every output is decoded from registered state, so no path exists from in_valid/in_data to any output.
module sync_frame_tx_1101 #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned GAP      = 2,
    parameter logic [3:0]  SYNC_PAT = 4'b1101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int unsigned CNT_MAX = (DATA_W > GAP) ? ((DATA_W > 4) ? DATA_W : 4)
                                                     : ((GAP > 4) ? GAP : 4);
    localparam int unsigned CW = $clog2(CNT_MAX);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [CW-1:0] SYNC_LAST = CW'(3);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LAST  = (GAP > 0) ? CW'(GAP - 1) : '0;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic              data_last;
    logic              gap_last;
    logic              accept;

    assign data_last = (state == S_DATA) && (cnt == DATA_LAST);
    assign gap_last  = (state == S_GAP) && (cnt == GAP_LAST);

    // The final cycle of a frame also accepts, so back-to-back frames have no idle bit.
    assign in_ready = (state == S_IDLE) || ((GAP == 0) ? data_last : gap_last);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_SYNC;
                        cnt   <= '0;
                        shreg <= in_data;
                    end
                end
                S_SYNC: begin
                    if (cnt == SYNC_LAST) begin
                        state <= S_DATA;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    shreg <= shreg << 1;
                    if (cnt == DATA_LAST) begin
                        cnt <= '0;
                        if (GAP > 0) begin
                            state <= S_GAP;
                        end else if (accept) begin
                            state <= S_SYNC;
                            shreg <= in_data;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (accept) begin
                            state <= S_SYNC;
                            shreg <= in_data;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        out        = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_SYNC: begin
                out       = SYNC_PAT[2'd3 - cnt[1:0]];
                out_valid = 1'b1;
            end
            S_DATA: begin
                out        = shreg[DATA_W-1];
                out_valid  = 1'b1;
                frame_done = (cnt == DATA_LAST);
            end
            default: begin
                out        = 1'b0;
                out_valid  = 1'b0;
                frame_done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sync_frame_tx_1101.sv
// Bench for sync_frame_tx_1101: two instances (8-bit/GAP 2 and 4-bit/GAP 0) checked against a frame-queue model.
module tb_sync_frame_tx_1101;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] vld;
    logic [1:0] rdy;
    logic [1:0] so;
    logic [1:0] sv;
    logic [1:0] fd;
    logic [7:0] din [2];

    sync_frame_tx_1101 #(.DATA_W(8), .GAP(2), .SYNC_PAT(4'b1101)) dut_w8 (
        .clk(clk), .rst(rst[0]), .in_data(din[0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .out(so[0]), .out_valid(sv[0]), .frame_done(fd[0])
    );

    sync_frame_tx_1101 #(.DATA_W(4), .GAP(0), .SYNC_PAT(4'b1101)) dut_w4 (
        .clk(clk), .rst(rst[1]), .in_data(din[1][3:0]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .out(so[1]), .out_valid(sv[1]), .frame_done(fd[1])
    );

    int checks   = 0;
    int failures = 0;

    // Model: queue of {out, out_valid, frame_done} still to be shown; head = current cycle.
    logic [2:0] q    [2][$];
    logic [2:0] hist [2][$];
    int         acc_t[2][$];
    bit         acc_last[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_frame(input int d, input logic [7:0] w);
        int         nw = (d == 0) ? 8 : 4;
        int         ng = (d == 0) ? 2 : 0;
        logic [3:0] sp = 4'b1101;
        for (int i = 0; i < 4; i++) q[d].push_back({sp[3-i], 1'b1, 1'b0});
        for (int i = 0; i < nw; i++) q[d].push_back({w[nw-1-i], 1'b1, (i == nw - 1)});
        for (int i = 0; i < ng; i++) q[d].push_back(3'b000);
    endfunction

    task automatic step();
        bit         acc [2];
        logic [2:0] e;
        for (int d = 0; d < 2; d++) acc[d] = vld[d] && (q[d].size() <= 1) && !rst[d];
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            acc_last[d] = acc[d];
            if (rst[d]) begin
                q[d].delete();
            end else begin
                if (q[d].size() > 0) void'(q[d].pop_front());
                if (acc[d]) begin
                    push_frame(d, din[d]);
                    acc_t[d].push_back(hist[d].size());
                end
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            e = (q[d].size() > 0) ? q[d][0] : 3'b000;
            check($sformatf("out%0d", d), so[d], e[2]);
            check($sformatf("out_valid%0d", d), sv[d], e[1]);
            check($sformatf("frame_done%0d", d), fd[d], e[0]);
            check($sformatf("in_ready%0d", d), rdy[d], (q[d].size() <= 1));
            hist[d].push_back({so[d], sv[d], fd[d]});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input int d, input logic [7:0] w);
        din[d] = w;
        vld[d] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (acc_last[d]) break;
        end
        check($sformatf("accept%0d", d), acc_last[d], 1);
        vld[d] = 1'b0;
    endtask

    task automatic detect(input int a, output int n, output int first, output int second);
        logic [3:0] win;
        n = 0; first = -1; second = -1;
        for (int p = a; p < a + 20; p++) begin
            win = {hist[0][p-3][2], hist[0][p-2][2], hist[0][p-1][2], hist[0][p][2]};
            if (win == 4'b1101) begin
                n++;
                if (n == 1) first = p - a + 1;
                else if (n == 2) second = p - a + 1;
            end
        end
    endtask

    initial begin
        int          a;
        int          n;
        int          p1;
        int          p2;
        int          cnt;
        logic [15:0] e_out;
        logic [15:0] e_val;
        logic [15:0] e_fd;

        rst = 2'b11; vld = 2'b00; din[0] = '0; din[1] = '0;
        idle(2);
        rst = 2'b00;
        check("rst_out", so, 2'b00);
        check("rst_valid", sv, 2'b00);
        check("rst_done", fd, 2'b00);
        check("rst_ready", rdy, 2'b11);
        idle(2);

        // Single frame A5
        send(0, 8'hA5);
        a = acc_t[0][$];
        idle(16);
        e_out = 16'b1101_10100101_0000;
        e_val = 16'b1111_11111111_0000;
        e_fd  = 16'b0000_00000001_0000;
        for (int i = 0; i < 16; i++) begin
            check("a5_out", hist[0][a+i][2], e_out[15-i]);
            check("a5_valid", hist[0][a+i][1], e_val[15-i]);
            check("a5_done", hist[0][a+i][0], e_fd[15-i]);
        end

        // Back-to-back with in_valid held
        send(0, 8'hFF);
        send(0, 8'h00);
        check("b2b_period", acc_t[0][$] - acc_t[0][$-1], 14);
        idle(20);

        // Loopback into an overlapping 1101 detector
        send(0, 8'h00);
        a = acc_t[0][$];
        idle(20);
        detect(a, n, p1, p2);
        check("det00_count", n, 1);
        check("det00_pos", p1, 4);
        send(0, 8'h0D);
        a = acc_t[0][$];
        idle(20);
        detect(a, n, p1, p2);
        check("det0d_count", n, 2);
        check("det0d_pos1", p1, 4);
        check("det0d_pos2", p2, 12);

        // Reset during payload bit 3 of C3
        send(0, 8'hC3);
        a = acc_t[0][$];
        idle(6);
        check("c3_bit3", {so[0], sv[0]}, 2'b01);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        check("abort_out", so[0], 0);
        check("abort_valid", sv[0], 0);
        check("abort_ready", rdy[0], 1);
        idle(20);
        cnt = 0;
        for (int i = a; i < hist[0].size(); i++) cnt += hist[0][i][0];
        check("abort_no_done", cnt, 0);
        send(0, 8'h3C);
        idle(16);

        // in_valid pulse during SYNC must be ignored
        send(0, 8'hAA);
        a = acc_t[0][$];
        n = acc_t[0].size();
        step();
        din[0] = 8'h55;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        idle(20);
        check("pulse_accepts", acc_t[0].size(), n);
        cnt = 0;
        for (int i = a + 12; i < hist[0].size(); i++) cnt += hist[0][i][1];
        check("pulse_no_frame", cnt, 0);

        // GAP=0, DATA_W=4, back-to-back 9 then 6
        send(1, 8'h09);
        a = acc_t[1][$];
        send(1, 8'h06);
        check("g0_period", acc_t[1][$] - acc_t[1][$-1], 8);
        idle(10);
        e_out = 16'b1101_1001_1101_0110;
        for (int i = 0; i < 16; i++) begin
            check("g0_out", hist[1][a+i][2], e_out[15-i]);
            check("g0_valid", hist[1][a+i][1], 1);
        end
        check("g0_end_valid", hist[1][a+16][1], 0);

        // Randomized traffic and resets on both instances
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                rst[d] = ($urandom_range(0, 63) == 0);
                if (vld[d] && acc_last[d]) vld[d] = 1'b0;
                if (!vld[d] && $urandom_range(0, 2) == 0) begin
                    vld[d] = 1'b1;
                    din[d] = (d == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
                end else if (vld[d] && $urandom_range(0, 31) == 0) begin
                    vld[d] = 1'b0;
                end
            end
            step();
        end
        rst = 2'b00;
        vld = 2'b00;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
